psimd_issue_queue: RTL and testbench

//  Core-side issuer for the PSIMD unit. It is the transmitting end of the instr/rs1_core interface.
//  - Accepts instruction/rs1 pairs from the scalar core over a valid/ready handshake.
//  - Buffers them in a FIFO and issues them in order to PSIMD under a second valid/ready handshake.
//  - Tracks outstanding ops and accumulates PSIMD per-lane exception flags into a sticky 5-bit fflags.

---
 rtl/psimd_pkg.sv | 26 ++
 rtl/psimd_sync_fifo.sv | 62 ++++++
 rtl/psimd_issue_queue.sv | 134 +++++++++++++
 tb/tb_psimd_issue_queue.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psimd_pkg.sv
// rtl/psimd_pkg.sv - PSIMD issue field slices, flag indices and shared types
package psimd_pkg;

    localparam int RD_LO  = 7;
    localparam int RD_HI  = 11;
    localparam int RS1_LO = 15;
    localparam int RS1_HI = 19;
    localparam int RS2_LO = 20;
    localparam int RS2_HI = 24;
    localparam int RS3_LO = 27;
    localparam int RS3_HI = 31;

    localparam int FF_NX = 0;
    localparam int FF_UF = 1;
    localparam int FF_OF = 2;
    localparam int FF_DZ = 3;
    localparam int FF_NV = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
    } psimd_issue_t;

    typedef logic [4:0] fflags_t;

endpackage

// File: rtl/psimd_sync_fifo.sv
// rtl/psimd_sync_fifo.sv - show-ahead synchronous FIFO exposing slot contents for hazard scans
module psimd_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       push_data,
    output logic                   full,
    output logic                   empty,
    output logic [WIDTH-1:0]       head,
    output logic [DEPTH-1:0]       slot_valid,
    output logic [DEPTH*WIDTH-1:0] slots
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] mem [DEPTH];

    assign count = wptr - rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + 1'b1;
            if (pop && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= push_data;
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        logic [AW-1:0] off;
        slot_valid = '0;
        off        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off           = AW'(i) - rptr[AW-1:0];
            slot_valid[i] = ({1'b0, off} < count);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slots
        assign slots[g*WIDTH +: WIDTH] = mem[g];
    end

endmodule

// File: rtl/psimd_issue_queue.sv
// rtl/psimd_issue_queue.sv - core-side PSIMD issuer; PSIMD_RAW_STALL_EN adds an rd-based RAW hold
module psimd_issue_queue
    import psimd_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_valid,
    output logic        core_ready,
    input  logic [31:0] core_instr,
    input  logic [31:0] core_rs1,
    output logic        psimd_valid,
    input  logic        psimd_ready,
    output logic [31:0] psimd_instr,
    output logic [31:0] psimd_rs1,
    input  logic        wb_valid,
    input  logic [3:0]  invalid,
    input  logic [3:0]  inexact,
    input  logic [3:0]  overflow,
    input  logic [3:0]  underflow,
    input  logic [3:0]  div_by_zero,
    input  logic        fflags_clr,
    output fflags_t     fflags,
    output logic [3:0]  outstanding,
    output logic        busy,
    output logic        wb_err
);

    psimd_issue_t push_data;
    psimd_issue_t head;
    logic         full;
    logic         empty;
    logic         stall;
    logic         hazard;
    logic         issue;
    fflags_t      fold;

    logic [DEPTH-1:0]                    issue_slot_valid_unused;
    logic [DEPTH*$bits(psimd_issue_t)-1:0] issue_slots_unused;

    assign push_data = '{instr: core_instr, rs1: core_rs1};

    psimd_sync_fifo #(.WIDTH($bits(psimd_issue_t)), .DEPTH(DEPTH)) u_issue_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (core_valid),
        .pop        (issue),
        .push_data  (push_data),
        .full       (full),
        .empty      (empty),
        .head       (head),
        .slot_valid (issue_slot_valid_unused),
        .slots      (issue_slots_unused)
    );

`ifdef PSIMD_RAW_STALL_EN
    // Outstanding is capped at MAX_OUTSTANDING, so a power-of-two rounding never overflows.
    localparam int RD_DEPTH = (MAX_OUTSTANDING <= 2) ? 2 : (1 << $clog2(MAX_OUTSTANDING));

    logic [RD_DEPTH-1:0]   rd_valid;
    logic [RD_DEPTH*5-1:0] rd_slots;
    logic                  rd_full_unused;
    logic                  rd_empty_unused;
    logic [4:0]            rd_head_unused;

    psimd_sync_fifo #(.WIDTH(5), .DEPTH(RD_DEPTH)) u_rd_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (issue),
        .pop        (wb_valid),
        .push_data  (head.instr[RD_HI:RD_LO]),
        .full       (rd_full_unused),
        .empty      (rd_empty_unused),
        .head       (rd_head_unused),
        .slot_valid (rd_valid),
        .slots      (rd_slots)
    );

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < RD_DEPTH; i++) begin
            if (rd_valid[i] &&
                ((rd_slots[i*5 +: 5] == head.instr[RS1_HI:RS1_LO]) ||
                 (rd_slots[i*5 +: 5] == head.instr[RS2_HI:RS2_LO]) ||
                 (rd_slots[i*5 +: 5] == head.instr[RS3_HI:RS3_LO])))
                hazard = 1'b1;
        end
    end
`else
    assign hazard = 1'b0;
`endif

    assign core_ready  = !full;
    assign stall       = (outstanding == 4'(MAX_OUTSTANDING));
    assign psimd_valid = !empty && !stall && !hazard;
    assign issue       = psimd_valid && psimd_ready;
    assign psimd_instr = empty ? 32'd0 : head.instr;
    assign psimd_rs1   = empty ? 32'd0 : head.rs1;
    assign busy        = !empty || (outstanding != 4'd0);

    always_comb begin
        fold        = '0;
        fold[FF_NV] = |invalid;
        fold[FF_DZ] = |div_by_zero;
        fold[FF_OF] = |overflow;
        fold[FF_UF] = |underflow;
        fold[FF_NX] = |inexact;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= 4'd0;
            fflags      <= '0;
            wb_err      <= 1'b0;
        end else begin
            if (issue && !wb_valid)
                outstanding <= outstanding + 4'd1;
            else if (wb_valid && !issue && outstanding != 4'd0)
                outstanding <= outstanding - 4'd1;

            if (wb_valid && outstanding == 4'd0)
                wb_err <= 1'b1;

            // Clear takes effect before this cycle's writeback flags are merged.
            if (fflags_clr)
                fflags <= wb_valid ? fold : '0;
            else if (wb_valid)
                fflags <= fflags | fold;
        end
    end

endmodule

// File: tb/tb_psimd_issue_queue.sv
// tb/tb_psimd_issue_queue.sv - directed and randomized bench for psimd_issue_queue
module tb_psimd_issue_queue;

    localparam int DEPTH = 4;
    localparam int MAXO  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_valid;
    logic        core_ready;
    logic [31:0] core_instr;
    logic [31:0] core_rs1;
    logic        psimd_valid;
    logic        psimd_ready;
    logic [31:0] psimd_instr;
    logic [31:0] psimd_rs1;
    logic        wb_valid;
    logic [3:0]  invalid;
    logic [3:0]  inexact;
    logic [3:0]  overflow;
    logic [3:0]  underflow;
    logic [3:0]  div_by_zero;
    logic        fflags_clr;
    logic [4:0]  fflags;
    logic [3:0]  outstanding;
    logic        busy;
    logic        wb_err;

    psimd_issue_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk         (clk),
        .rst         (rst),
        .core_valid  (core_valid),
        .core_ready  (core_ready),
        .core_instr  (core_instr),
        .core_rs1    (core_rs1),
        .psimd_valid (psimd_valid),
        .psimd_ready (psimd_ready),
        .psimd_instr (psimd_instr),
        .psimd_rs1   (psimd_rs1),
        .wb_valid    (wb_valid),
        .invalid     (invalid),
        .inexact     (inexact),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero),
        .fflags_clr  (fflags_clr),
        .fflags      (fflags),
        .outstanding (outstanding),
        .busy        (busy),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
    } ent_t;

    ent_t       q[$];
    logic [4:0] pend[$];
    int         m_out = 0;
    logic [4:0] m_ff  = '0;
    logic       m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hazard();
`ifdef PSIMD_RAW_STALL_EN
        if (q.size() == 0) return 1'b0;
        foreach (pend[i])
            if (pend[i] == q[0].instr[19:15] || pend[i] == q[0].instr[24:20] ||
                pend[i] == q[0].instr[31:27])
                return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic bit m_valid();
        return (q.size() != 0) && (m_out != MAXO) && !m_hazard();
    endfunction

    // Reference model: advances on each rising edge from the inputs held across it.
    always @(posedge clk) begin : model
        bit         do_push;
        bit         do_issue;
        logic [4:0] nw;
        ent_t       e;
        if (rst) begin
            q.delete();
            pend.delete();
            m_out = 0;
            m_ff  = '0;
            m_err = 1'b0;
        end else begin
            do_push  = core_valid && (q.size() != DEPTH);
            do_issue = m_valid() && psimd_ready;
            nw = {|invalid, |div_by_zero, |overflow, |underflow, |inexact};
            if (wb_valid && m_out == 0) m_err = 1'b1;
            if (do_issue && !wb_valid) m_out++;
            else if (wb_valid && !do_issue && m_out > 0) m_out--;
            if (fflags_clr) m_ff = wb_valid ? nw : 5'd0;
            else if (wb_valid) m_ff = m_ff | nw;
            if (wb_valid && pend.size() > 0) void'(pend.pop_front());
            if (do_issue) begin
                pend.push_back(q[0].instr[11:7]);
                void'(q.pop_front());
            end
            if (do_push) begin
                e.instr = core_instr;
                e.rs1   = core_rs1;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("core_ready",  32'(core_ready),  32'(q.size() != DEPTH));
            chk("psimd_valid", 32'(psimd_valid), 32'(m_valid()));
            chk("psimd_instr", psimd_instr, (q.size() != 0) ? q[0].instr : 32'd0);
            chk("psimd_rs1",   psimd_rs1,   (q.size() != 0) ? q[0].rs1   : 32'd0);
            chk("fflags",      32'(fflags),      32'(m_ff));
            chk("outstanding", 32'(outstanding), 32'(m_out));
            chk("busy",        32'(busy),        32'(q.size() != 0 || m_out != 0));
            chk("wb_err",      32'(wb_err),      32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int cyc;
        rst = 1'b1; core_valid = 0; core_instr = 0; core_rs1 = 0; psimd_ready = 0;
        wb_valid = 0; invalid = 0; inexact = 0; overflow = 0; underflow = 0;
        div_by_zero = 0; fflags_clr = 0;
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;

        chk("rst_instr", psimd_instr, 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_core_ready", 32'(core_ready), 32'd1);
            chk("idle_psimd_valid", 32'(psimd_valid), 32'd0);
            chk("idle_fflags", 32'(fflags), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Fill with PSIMD back-pressured, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            core_valid = 1'b1;
            core_instr = 32'h1000_0000 + 32'(i);
            core_rs1   = 32'(i);
            step();
        end
        core_valid = 1'b0;
        chk("fill_core_ready", 32'(core_ready), 32'd0);
        chk("fill_head", psimd_instr, 32'h1000_0001);
        psimd_ready = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 40) begin
`ifdef PSIMD_RAW_STALL_EN
            wb_valid = !psimd_valid;
`endif
            if (psimd_valid) begin
                chk("drain_order", psimd_instr, 32'h1000_0000 + 32'(n + 1));
                n++;
            end
            step();
            cyc++;
        end
        wb_valid = 1'b0;
        psimd_ready = 1'b0;
        chk("drain_count", 32'(n), 32'd4);
`ifndef PSIMD_RAW_STALL_EN
        chk("drain_cycles", 32'(cyc), 32'd4);
`endif

        // Outstanding limit: fifth op waits for one writeback.
        do_reset();
        psimd_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            core_valid = 1'b1;
            core_instr = 32'(i) << 7;
            core_rs1   = 32'(i);
            step();
        end
        core_valid = 1'b0;
        chk("lim_outstanding", 32'(outstanding), 32'd4);
        chk("lim_held", 32'(psimd_valid), 32'd0);
        step();
        chk("lim_still_held", 32'(psimd_valid), 32'd0);
        wb_valid = 1'b1;
        chk("lim_wb_no_unstall", 32'(psimd_valid), 32'd0);
        step();
        wb_valid = 1'b0;
        chk("lim_released", 32'(psimd_valid), 32'd1);
        chk("lim_after_wb", 32'(outstanding), 32'd3);
        chk("lim_fifth_head", psimd_instr, 32'h0000_0280);
        step();
        chk("lim_refilled", 32'(outstanding), 32'd4);
        psimd_ready = 1'b0;

        // Sticky flags and clear-then-set.
        wb_valid = 1'b1;
        overflow = 4'b0100;
        step();
        chk("flags_of", 32'(fflags), 32'h04);
        overflow = 4'b0000;
        inexact = 4'b0001;
        fflags_clr = 1'b1;
        step();
        wb_valid = 1'b0;
        inexact = 4'b0000;
        fflags_clr = 1'b0;
        chk("flags_clr_set", 32'(fflags), 32'h01);
        chk("flags_outstanding", 32'(outstanding), 32'd2);

        // Writeback with nothing outstanding.
        do_reset();
        wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
        chk("err_set", 32'(wb_err), 32'd1);
        chk("err_outstanding", 32'(outstanding), 32'd0);
        do_reset();
        chk("err_cleared", 32'(wb_err), 32'd0);

        // RAW: rd=5 in flight, next head reads rs2=5.
        psimd_ready = 1'b1;
        core_valid = 1'b1;
        core_instr = 32'h0000_0280;
        step();
        core_instr = 32'h0050_0000;
        step();
        core_valid = 1'b0;
        chk("raw_outstanding", 32'(outstanding), 32'd1);
        chk("raw_head", psimd_instr, 32'h0050_0000);
`ifdef PSIMD_RAW_STALL_EN
        chk("raw_hold", 32'(psimd_valid), 32'd0);
        step();
        chk("raw_hold2", 32'(psimd_valid), 32'd0);
        wb_valid = 1'b1;
        chk("raw_hold_wb", 32'(psimd_valid), 32'd0);
        step();
        wb_valid = 1'b0;
        chk("raw_release", 32'(psimd_valid), 32'd1);
`else
        chk("raw_no_check", 32'(psimd_valid), 32'd1);
`endif
        step();
        psimd_ready = 1'b0;

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rst         = ($urandom_range(0, 199) == 0);
            core_valid  = $urandom_range(0, 1);
            core_instr  = $urandom;
            core_rs1    = $urandom;
            psimd_ready = ($urandom_range(0, 3) != 0);
            wb_valid    = ($urandom_range(0, 2) == 0);
            invalid     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            inexact     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            overflow    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            underflow   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            div_by_zero = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            fflags_clr  = ($urandom_range(0, 15) == 0);
            step();
        end
        rst = 0; core_valid = 0; psimd_ready = 0; wb_valid = 0; fflags_clr = 0;
        invalid = 0; inexact = 0; overflow = 0; underflow = 0; div_by_zero = 0;
        step();
        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
